// File: rtl/axils_reg_slave.sv
// ----------------------------------------------------------------------------
// axils_reg_slave
//
// AXI4-Lite slave with NUM_REGS 32-bit read/write registers, word-aligned
// from offset 0x0. Register contents and per-register write strobes are
// exported to downstream control logic.
//
// Parameters
//   NUM_REGS    number of 32-bit registers (1..256)
//   ADDR_WIDTH  low address bits decoded; upper address bits are ignored
//
// Ports
//   ACLK, ARESETN              clock (rising edge), synchronous active-low reset
//   AXI_AW*                    write address channel (CACHE/PROT ignored)
//   AXI_W*                     write data channel with byte strobes
//   AXI_B*                     write response channel
//   AXI_AR*                    read address channel (CACHE/PROT ignored)
//   AXI_R*                     read data channel
//   REG_OUT                    register contents, reg i at [32*i+31:32*i]
//   REG_WE                     one-cycle pulse on the cycle after reg i is written
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where VALID and READY are both high. A source holds VALID and its payload
// stable until that edge; this slave never withdraws RVALID/BVALID or changes
// RDATA/RRESP/BRESP before the master accepts them.
// ----------------------------------------------------------------------------
module axils_reg_slave #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  // write address
  input  logic [31:0]              AXI_AWADDR,
  input  logic [3:0]               AXI_AWCACHE,
  input  logic [2:0]               AXI_AWPROT,
  input  logic                     AXI_AWVALID,
  output logic                     AXI_AWREADY,
  // write data
  input  logic [31:0]              AXI_WDATA,
  input  logic [3:0]               AXI_WSTRB,
  input  logic                     AXI_WVALID,
  output logic                     AXI_WREADY,
  // write response
  output logic                     AXI_BVALID,
  input  logic                     AXI_BREADY,
  output logic [1:0]               AXI_BRESP,
  // read address
  input  logic [31:0]              AXI_ARADDR,
  input  logic [3:0]               AXI_ARCACHE,
  input  logic [2:0]               AXI_ARPROT,
  input  logic                     AXI_ARVALID,
  output logic                     AXI_ARREADY,
  // read data
  output logic [31:0]              AXI_RDATA,
  output logic [1:0]               AXI_RRESP,
  output logic                     AXI_RVALID,
  input  logic                     AXI_RREADY,
  // register side
  output logic [NUM_REGS*32-1:0]   REG_OUT,
  output logic [NUM_REGS-1:0]      REG_WE
);

  localparam int          IDXW   = ADDR_WIDTH - 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]          r_regs [NUM_REGS];

  // Write path: AW and W are captured independently; each flag blocks its
  // own channel until the pair has been committed.
  logic                 r_aw_ok;
  logic                 r_w_ok;
  logic [IDXW-1:0]      r_widx;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic [NUM_REGS-1:0]  r_reg_we;

  // Read path
  logic                 r_rvalid;
  logic [1:0]           r_rresp;
  logic [31:0]          r_rdata;

  // --------------------------------------------------------------------------
  // Handshakes and decode
  // --------------------------------------------------------------------------
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_b_hs;
  logic                 w_ar_hs;
  logic                 w_r_hs;
  logic                 w_commit;
  logic [NUM_REGS-1:0]  w_wr_hit;
  logic                 w_wr_in_range;
  logic [IDXW-1:0]      w_ridx;
  logic [NUM_REGS-1:0]  w_rd_hit;
  logic                 w_rd_in_range;
  logic [31:0]          w_rd_data;
  logic                 w_unused;

  assign AXI_AWREADY = !r_aw_ok && !r_bvalid;
  assign AXI_WREADY  = !r_w_ok  && !r_bvalid;
  assign AXI_ARREADY = !r_rvalid;

  assign w_aw_hs  = AXI_AWVALID && AXI_AWREADY;
  assign w_w_hs   = AXI_WVALID  && AXI_WREADY;
  assign w_b_hs   = r_bvalid    && AXI_BREADY;
  assign w_ar_hs  = AXI_ARVALID && AXI_ARREADY;
  assign w_r_hs   = r_rvalid    && AXI_RREADY;

  // Commit on the edge after both halves of the write are held.
  assign w_commit = r_aw_ok && r_w_ok;

  assign w_ridx   = AXI_ARADDR[ADDR_WIDTH-1:2];

  // One-hot decode; an index with no matching register is out of range.
  always_comb begin
    w_wr_hit = '0;
    w_rd_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_hit[i] = (r_widx == IDXW'(i));
      w_rd_hit[i] = (w_ridx == IDXW'(i));
    end
  end

  assign w_wr_in_range = |w_wr_hit;
  assign w_rd_in_range = |w_rd_hit;

  // Out-of-range reads return zero because no hit bit is set.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_hit[i]) begin
        w_rd_data = r_regs[i];
      end
    end
  end

  // Cache/prot attributes and address bits outside the decoded field are
  // accepted but have no effect on this slave.
  assign w_unused = ^{AXI_AWCACHE, AXI_AWPROT, AXI_ARCACHE, AXI_ARPROT,
                      AXI_AWADDR, AXI_ARADDR};

  // --------------------------------------------------------------------------
  // Write channel control
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_aw_ok  <= 1'b0;
      r_w_ok   <= 1'b0;
      r_widx   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
      r_reg_we <= '0;
    end else begin
      r_reg_we <= '0;

      if (w_commit) begin
        r_aw_ok  <= 1'b0;
        r_w_ok   <= 1'b0;
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_in_range ? OKAY : SLVERR;
        // Pulses even for an all-zero strobe: the write still happened.
        if (w_wr_in_range) begin
          r_reg_we <= w_wr_hit;
        end
      end else begin
        if (w_aw_hs) begin
          r_widx  <= AXI_AWADDR[ADDR_WIDTH-1:2];
          r_aw_ok <= 1'b1;
        end
        if (w_w_hs) begin
          r_wdata <= AXI_WDATA;
          r_wstrb <= AXI_WSTRB;
          r_w_ok  <= 1'b1;
        end
      end

      // Commit and response acceptance cannot coincide: while BVALID is
      // high neither capture flag can be set.
      if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hit[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) begin
              r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read channel
  // --------------------------------------------------------------------------
  // A read sampled on the same edge as a commit to the same register sees
  // the value from before the write, since both use non-blocking updates.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rresp  <= OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_in_range ? OKAY : SLVERR;
      r_rvalid <= 1'b1;
    end else if (w_r_hs) begin
      // RDATA is left as-is; it is meaningless once RVALID drops.
      r_rvalid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign AXI_BVALID = r_bvalid;
  assign AXI_BRESP  = r_bresp;
  assign AXI_RVALID = r_rvalid;
  assign AXI_RRESP  = r_rresp;
  assign AXI_RDATA  = r_rdata;
  assign REG_WE     = r_reg_we;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign REG_OUT[32*g +: 32] = r_regs[g];
  end

endmodule

// File: tb/tb_axils_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axils_reg_slave
//
// Directed bench for axils_reg_slave (NUM_REGS=8, ADDR_WIDTH=12). Inputs
// change 1 ns after each rising edge; outputs are sampled at the same point,
// after the edge's register updates have settled.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axils_reg_slave;

  localparam int NUM_REGS   = 8;
  localparam int ADDR_WIDTH = 12;

  // --------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // --------------------------------------------------------------------------
  logic                   aclk;
  logic                   aresetn;
  logic [31:0]            awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  logic [31:0]            araddr;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic [NUM_REGS*32-1:0] reg_out;
  logic [NUM_REGS-1:0]    reg_we;

  logic [31:0]            exp_regs [NUM_REGS];
  int                     n_asserts;
  int                     n_fail;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  axils_reg_slave #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .ACLK        (aclk),
    .ARESETN     (aresetn),
    .AXI_AWADDR  (awaddr),
    .AXI_AWCACHE (4'h3),
    .AXI_AWPROT  (3'h2),
    .AXI_AWVALID (awvalid),
    .AXI_AWREADY (awready),
    .AXI_WDATA   (wdata),
    .AXI_WSTRB   (wstrb),
    .AXI_WVALID  (wvalid),
    .AXI_WREADY  (wready),
    .AXI_BVALID  (bvalid),
    .AXI_BREADY  (bready),
    .AXI_BRESP   (bresp),
    .AXI_ARADDR  (araddr),
    .AXI_ARCACHE (4'h3),
    .AXI_ARPROT  (3'h2),
    .AXI_ARVALID (arvalid),
    .AXI_ARREADY (arready),
    .AXI_RDATA   (rdata),
    .AXI_RRESP   (rresp),
    .AXI_RVALID  (rvalid),
    .AXI_RREADY  (rready),
    .REG_OUT     (reg_out),
    .REG_WE      (reg_we)
  );

  // --------------------------------------------------------------------------
  // Driver / checker tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s_reg%0d", tag, i), reg_out[32*i +: 32], exp_regs[i]);
    end
  endtask

  // Full write with AW and W together; assumes BREADY is high.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    awaddr  = addr;
    awvalid = 1'b1;
    wdata   = data;
    wstrb   = strb;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tick();
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    n_asserts = 0;
    n_fail    = 0;
    aresetn   = 1'b0;
    awaddr    = '0;
    awvalid   = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wvalid    = 1'b0;
    bready    = 1'b1;
    araddr    = '0;
    arvalid   = 1'b0;
    rready    = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;

    // Reset state
    tick();
    tick();
    aresetn = 1'b1;
    check("rst_awready", awready, 1);
    check("rst_wready",  wready,  1);
    check("rst_arready", arready, 1);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rvalid",  rvalid,  0);
    check("rst_bresp",   bresp,   0);
    check("rst_rresp",   rresp,   0);
    check("rst_rdata",   rdata,   0);
    check("rst_reg_we",  reg_we,  0);
    check_regs("rst");

    // 1: AW and W in the same cycle
    awaddr = 32'h4; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'b1111; wvalid = 1'b1;
    check("t1_awready_pre", awready, 1);
    check("t1_wready_pre",  wready,  1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_bvalid_n",  bvalid,  0);
    check("t1_awready_n", awready, 0);
    check("t1_wready_n",  wready,  0);
    tick();
    exp_regs[1] = 32'hDEADBEEF;
    check("t1_bvalid",  bvalid, 1);
    check("t1_bresp",   bresp,  0);
    check("t1_reg_we",  reg_we, 32'h02);
    check_regs("t1");
    tick();
    check("t1_bvalid_done", bvalid,  0);
    check("t1_reg_we_done", reg_we,  0);
    check("t1_awready_ret", awready, 1);
    check("t1_wready_ret",  wready,  1);

    // 2: W first, AW three cycles later, partial strobes over a preloaded reg
    do_write(32'h8, 32'hFFFFFFFF, 4'b1111);
    exp_regs[2] = 32'hFFFFFFFF;
    check_regs("t2_pre");
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("t2_wready_held",  wready,  0);
    check("t2_awready_open", awready, 1);
    tick();
    check("t2_bvalid_wait1", bvalid, 0);
    tick();
    check("t2_bvalid_wait2", bvalid, 0);
    awaddr = 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t2_bvalid_aw", bvalid, 0);
    tick();
    exp_regs[2] = 32'hFF22FF44;
    check("t2_bvalid", bvalid, 1);
    check("t2_bresp",  bresp,  0);
    check("t2_reg_we", reg_we, 32'h04);
    check_regs("t2");
    tick();
    check("t2_bvalid_done", bvalid, 0);
    tick();
    check("t2_single_resp", bvalid, 0);

    // 3: out-of-range write and read
    awaddr = 32'h40; awvalid = 1'b1;
    wdata = 32'h12345678; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("t3_bvalid", bvalid, 1);
    check("t3_bresp",  bresp,  2);
    check("t3_reg_we", reg_we, 0);
    check_regs("t3");
    tick();
    check("t3_bvalid_done", bvalid, 0);
    araddr = 32'h40; arvalid = 1'b1;
    check("t3_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check("t3_rvalid", rvalid, 1);
    check("t3_rdata",  rdata,  0);
    check("t3_rresp",  rresp,  2);
    tick();
    check("t3_rvalid_done", rvalid, 0);

    // 4: response back-pressure holds off a new write
    bready = 1'b0;
    awaddr = 32'hC; awvalid = 1'b1;
    wdata = 32'hA5A5A5A5; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    exp_regs[3] = 32'hA5A5A5A5;
    awaddr = 32'h10; awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_bvalid_%0d", k),  bvalid,  1);
      check($sformatf("t4_bresp_%0d", k),   bresp,   0);
      check($sformatf("t4_awready_%0d", k), awready, 0);
      check($sformatf("t4_wready_%0d", k),  wready,  0);
      tick();
    end
    check("t4_bvalid_held", bvalid, 1);
    check_regs("t4_stall");
    bready = 1'b1;
    wdata = 32'h0BADF00D; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    check("t4_bvalid_done", bvalid,  0);
    check("t4_awready_ret", awready, 1);
    check("t4_wready_ret",  wready,  1);
    check("t4_reg4_untouched", reg_out[159:128], 0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    exp_regs[4] = 32'h0BADF00D;
    check("t4_bvalid2", bvalid, 1);
    check("t4_reg_we",  reg_we, 32'h10);
    check_regs("t4");
    tick();

    // 5: read held under RREADY low, concurrent write to the same register
    rready = 1'b0;
    awaddr = 32'hC; awvalid = 1'b1;
    wdata = 32'h5A5A0000; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    exp_regs[3] = 32'h5A5A0000;
    check("t5_rvalid",  rvalid, 1);
    check("t5_rdata_old", rdata, 32'hA5A5A5A5);
    check("t5_rresp",   rresp,  0);
    check("t5_bvalid",  bvalid, 1);
    check_regs("t5");
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t5_rvalid_hold_%0d", k), rvalid,  1);
      check($sformatf("t5_rdata_hold_%0d", k),  rdata,   32'hA5A5A5A5);
      check($sformatf("t5_arready_%0d", k),     arready, 0);
    end
    rready = 1'b1;
    tick();
    check("t5_rvalid_done", rvalid,  0);
    check("t5_arready_ret", arready, 1);
    araddr = 32'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t5_rvalid2",    rvalid, 1);
    check("t5_rdata_new",  rdata,  32'h5A5A0000);
    check("t5_rresp2",     rresp,  0);
    tick();
    check("t5_rvalid2_done", rvalid, 0);

    // 6: reset with AW captured and W still pending
    awaddr = 32'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t6_awready_cap", awready, 0);
    check("t6_wready_open", wready,  1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    check("t6_awready", awready, 1);
    check("t6_wready",  wready,  1);
    check("t6_arready", arready, 1);
    check("t6_bvalid",  bvalid,  0);
    check("t6_rvalid",  rvalid,  0);
    check("t6_reg_we",  reg_we,  0);
    check_regs("t6");
    wdata = 32'hFFFFFFFF; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    tick();
    check("t6_no_resp",  bvalid,  0);
    check("t6_aw_clear", awready, 1);
    check("t6_w_held",   wready,  0);
    awaddr = 32'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    exp_regs[1] = 32'hFFFFFFFF;
    check("t6_bvalid2", bvalid, 1);
    check("t6_reg_we2", reg_we, 32'h02);
    check_regs("t6_post");
    tick();
    check("t6_bvalid2_done", bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
